// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer handshake bundle: control in, ROM address and status out.
// RetiredCount exists only when FETCH_SEQ_INSTR_COUNT_EN is defined.
interface fetch_sequencer_if #(
    parameter int unsigned A = 10
);
    logic         Start;
    logic         Stall;
    logic         Halt;
    logic         BranchEn;
    logic [A-1:0] Target;
    logic [A-1:0] InstAddress;
    logic         InstValid;
    logic         Busy;
    logic         Done;
    logic         Overrun;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
    logic [15:0]  RetiredCount;
`endif

    modport master (
        output Start, Stall, Halt, BranchEn, Target,
`ifdef FETCH_SEQ_INSTR_COUNT_EN
        input  RetiredCount,
`endif
        input  InstAddress, InstValid, Busy, Done, Overrun
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, Target,
`ifdef FETCH_SEQ_INSTR_COUNT_EN
        output RetiredCount,
`endif
        output InstAddress, InstValid, Busy, Done, Overrun
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter / fetch controller for a combinational instruction ROM.
// Define FETCH_SEQ_INSTR_COUNT_EN to add the saturating RetiredCount output.
module fetch_sequencer #(
    parameter int unsigned    A          = 10,
    parameter logic [A-1:0]   START_ADDR = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    fetch_sequencer_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic         overrun_q, overrun_d;
    logic [A:0]   pc_inc;

`ifdef FETCH_SEQ_INSTR_COUNT_EN
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif

    // Extra MSB catches the carry out of the top address.
    assign pc_inc = {1'b0, pc_q} + {{A{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        overrun_d = overrun_q;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            StRun: begin
                if (!bus.Stall) begin
`ifdef FETCH_SEQ_INSTR_COUNT_EN
                    cnt_d = cnt_inc;
`endif
                    if (bus.Halt) begin
                        state_d = StDone;
                    end else if (bus.BranchEn) begin
                        pc_d = bus.Target;
                    end else begin
                        pc_d = pc_inc[A-1:0];
                        if (pc_inc[A]) begin
                            overrun_d = 1'b1;
                            state_d   = StDone;
                        end
                    end
                end
            end
            default: begin
                // Idle and Done both accept Start the same way.
                if (bus.Start) begin
                    state_d   = StRun;
                    pc_d      = START_ADDR;
                    overrun_d = 1'b0;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
                    cnt_d     = 16'd0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            pc_q      <= START_ADDR;
            overrun_q <= 1'b0;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
            cnt_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstValid   = (state_q == StRun);
    assign bus.Busy        = (state_q == StRun);
    assign bus.Done        = (state_q == StDone);
    assign bus.Overrun     = overrun_q;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
    assign bus.RetiredCount = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, then random
// stimulus compared against a behavioural model.
module tb_fetch_sequencer;
    localparam int A   = 10;
    localparam int TOP = (1 << A) - 1;

    logic clk;
    logic rst;

    fetch_sequencer_if #(.A(A)) bus ();

    fetch_sequencer #(.A(A)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 finished.
    int m_mode = 0;
    int m_pc   = 0;
    int m_ovr  = 0;
    int m_cnt  = 0;

    typedef struct {
        bit rst, start, stall, halt, br;
        int tgt;
        int addr;
        bit busy, done, ovr;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit stl, input bit h,
                              input bit b, input int t);
        if (r) begin
            m_mode = 0; m_pc = 0; m_ovr = 0; m_cnt = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_ovr = 0; m_cnt = 0;
            end
        end else if (!stl) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (h) m_mode = 2;
            else if (b) m_pc = t;
            else if (m_pc == TOP) begin
                m_pc = 0; m_ovr = 1; m_mode = 2;
            end else m_pc = m_pc + 1;
        end
    endtask

    task automatic cycle(input bit r, input bit st, input bit stl, input bit h,
                         input bit b, input int t);
        rst          = r;
        bus.Start    = st;
        bus.Stall    = stl;
        bus.Halt     = h;
        bus.BranchEn = b;
        bus.Target   = t[A-1:0];
        @(posedge clk);
        model_step(r, st, stl, h, b, t);
        #1;
    endtask

    task automatic add(input bit r, input bit st, input bit stl, input bit h, input bit b,
                       input int t, input int addr, input bit busy, input bit done,
                       input bit ovr, input int cnt);
        vec_t v;
        v.rst = r; v.start = st; v.stall = stl; v.halt = h; v.br = b; v.tgt = t;
        v.addr = addr; v.busy = busy; v.done = done; v.ovr = ovr; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0; bus.Stall = 1'b0; bus.Halt = 1'b0;
        bus.BranchEn = 1'b0; bus.Target = '0;

        //  rst st stl h br tgt    addr busy done ovr cnt
        add(1, 1, 0, 0, 0, 0,     0,   0, 0, 0, 0);  // reset beats start
        add(1, 1, 0, 0, 0, 0,     0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,     1,   1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     2,   1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,     3,   1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,     4,   1, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0,     5,   1, 0, 0, 5);
        add(0, 0, 0, 1, 0, 0,     5,   0, 1, 0, 6);  // halt at 5
        add(0, 0, 0, 0, 0, 0,     5,   0, 1, 0, 6);
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,     1,   1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     2,   1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,     3,   1, 0, 0, 3);
        add(0, 0, 1, 0, 1, 40,    3,   1, 0, 0, 3);  // stall holds
        add(0, 0, 1, 1, 1, 40,    3,   1, 0, 0, 3);  // halt ignored under stall
        add(0, 0, 1, 0, 1, 40,    3,   1, 0, 0, 3);
        add(0, 0, 0, 0, 1, 40,    40,  1, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0,     41,  1, 0, 0, 5);
        add(0, 0, 0, 0, 1, TOP,   TOP, 1, 0, 0, 6);
        add(0, 0, 0, 0, 0, 0,     0,   0, 1, 1, 7);  // overrun wrap
        add(0, 0, 0, 0, 0, 0,     0,   0, 1, 1, 7);
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 200,   200, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,     0,   0, 0, 0, 0);  // reset mid-run
        add(0, 0, 0, 0, 0, 0,     0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 10,    10,  1, 0, 0, 1);
        add(0, 1, 0, 1, 1, 77,    10,  0, 1, 0, 2);  // halt beats branch
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);  // one Done cycle only
        add(0, 1, 0, 0, 0, 0,     1,   1, 0, 0, 1);  // start ignored in run
        add(0, 0, 0, 0, 1, TOP,   TOP, 1, 0, 0, 2);
        add(0, 0, 0, 1, 0, 0,     TOP, 0, 1, 0, 3);  // halt at top: no overrun
        add(0, 1, 0, 0, 0, 0,     0,   1, 0, 0, 0);
        add(0, 0, 0, 0, 1, TOP,   TOP, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, TOP,   TOP, 1, 0, 0, 2);  // self-loop at top
        add(1, 0, 0, 0, 0, 0,     0,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].br,
                  vecs[i].tgt);
            chk($sformatf("vec%0d addr", i), int'(bus.InstAddress), vecs[i].addr);
            chk($sformatf("vec%0d valid", i), int'(bus.InstValid), int'(vecs[i].busy));
            chk($sformatf("vec%0d busy", i), int'(bus.Busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d done", i), int'(bus.Done), int'(vecs[i].done));
            chk($sformatf("vec%0d overrun", i), int'(bus.Overrun), int'(vecs[i].ovr));
`ifdef FETCH_SEQ_INSTR_COUNT_EN
            chk($sformatf("vec%0d count", i), int'(bus.RetiredCount), vecs[i].cnt);
`endif
        end

        for (int i = 0; i < 3000; i++) begin
            bit r, st, stl, h, b;
            int t;
            r   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 39) == 0);
            b   = ($urandom_range(0, 7) == 0);
            t   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(TOP - 6, TOP))
                                              : int'($urandom_range(0, TOP));
            cycle(r, st, stl, h, b, t);
            chk("rnd addr", int'(bus.InstAddress), m_pc);
            chk("rnd valid", int'(bus.InstValid), int'(m_mode == 1));
            chk("rnd busy", int'(bus.Busy), int'(m_mode == 1));
            chk("rnd done", int'(bus.Done), int'(m_mode == 2));
            chk("rnd overrun", int'(bus.Overrun), m_ovr);
`ifdef FETCH_SEQ_INSTR_COUNT_EN
            chk("rnd count", int'(bus.RetiredCount), m_cnt);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
